// File: rtl/icache_refill_if.sv
// icache_refill_if: miss, network request/response and icache write bundle of the refill unit
interface icache_refill_if #(
  parameter int pc_width_p = 16,
  parameter int block_offset_width_p = 2
);
  logic miss_v_i;
  logic [pc_width_p-1:0] miss_pc_i;
  logic miss_ready_o;
  logic req_v_o;
  logic [pc_width_p-1:0] req_addr_o;
  logic req_yumi_i;
  logic resp_v_i;
  logic [block_offset_width_p-1:0] resp_offset_i;
  logic [31:0] resp_data_i;
  logic icache_v_o;
  logic [pc_width_p-1:0] icache_w_pc_o;
  logic [31:0] icache_w_instr_o;
  logic icache_yumi_i;
  logic busy_o;
  logic done_o;
  modport master (
    input miss_v_i, miss_pc_i, req_yumi_i, resp_v_i, resp_offset_i, resp_data_i, icache_yumi_i,
    output miss_ready_o, req_v_o, req_addr_o, icache_v_o, icache_w_pc_o, icache_w_instr_o, busy_o, done_o
  );
  modport slave (
    output miss_v_i, miss_pc_i, req_yumi_i, resp_v_i, resp_offset_i, resp_data_i, icache_yumi_i,
    input miss_ready_o, req_v_o, req_addr_o, icache_v_o, icache_w_pc_o, icache_w_instr_o, busy_o, done_o
  );
endinterface

// File: rtl/icache_refill_unit.sv
// icache_refill_unit: fetches a missed block word by word and writes it to the icache in offset order
module icache_refill_unit #(
  parameter int icache_tag_width_p = 8,
  parameter int icache_entries_p = 256,
  parameter int icache_block_size_in_words_p = 4
)(
  input logic clk_i,
  input logic reset_n_i,
  icache_refill_if.master io
);
  localparam int pc_width_lp = icache_tag_width_p + $clog2(icache_entries_p);
  localparam int block_offset_width_lp = icache_block_size_in_words_p > 1 ? $clog2(icache_block_size_in_words_p) : 1;
  localparam int bs_lp = icache_block_size_in_words_p;
  localparam logic [block_offset_width_lp:0] full_cnt = (block_offset_width_lp+1)'(bs_lp);
  localparam logic [block_offset_width_lp-1:0] last_off = block_offset_width_lp'(bs_lp-1);
  typedef enum logic [1:0] {s_idle, s_busy, s_done} state_e;
  state_e state, state_n;
  logic [pc_width_lp-1:0] base;
  logic [block_offset_width_lp:0] req_cnt, resp_cnt;
  logic [block_offset_width_lp-1:0] wr_ptr;
  logic [bs_lp-1:0] valid, valid_set, valid_clr;
  logic [31:0] mem [bs_lp];
  logic start, in_busy, req_fire, wr_fire, resp_err;
  always_ff @(posedge clk_i) state <= !reset_n_i ? s_idle : state_n;
  always_comb begin
    start = state == s_idle && io.miss_v_i;
    in_busy = state == s_busy;
    io.miss_ready_o = state == s_idle;
    io.busy_o = state != s_idle;
    io.done_o = state == s_done;
    io.req_v_o = in_busy && req_cnt < full_cnt;
    io.req_addr_o = base + pc_width_lp'(req_cnt);
    io.icache_v_o = in_busy && valid[wr_ptr];
    io.icache_w_pc_o = base | pc_width_lp'(wr_ptr);
    io.icache_w_instr_o = mem[wr_ptr];
    req_fire = io.req_v_o && io.req_yumi_i;
    wr_fire = io.icache_v_o && io.icache_yumi_i;
    valid_set = (in_busy && io.resp_v_i) ? bs_lp'(1) << io.resp_offset_i : '0;
    valid_clr = wr_fire ? bs_lp'(1) << wr_ptr : '0;
    state_n = state == s_idle ? (io.miss_v_i ? s_busy : s_idle)
            : state == s_busy ? ((wr_fire && wr_ptr == last_off) ? s_done : s_busy)
            : s_idle;
    // a response counts against requests already issued, including one handshaking this cycle
    resp_err = io.resp_v_i && (!in_busy || valid[io.resp_offset_i]
             || resp_cnt >= req_cnt + (block_offset_width_lp+1)'(req_fire));
  end
  always_ff @(posedge clk_i)
    if (!reset_n_i) begin
      base <= '0;
      req_cnt <= '0;
      resp_cnt <= '0;
      wr_ptr <= '0;
      valid <= '0;
    end else if (start) begin
      base <= io.miss_pc_i & ~pc_width_lp'(bs_lp-1);
      req_cnt <= '0;
      resp_cnt <= '0;
      wr_ptr <= '0;
      valid <= '0;
    end else begin
      req_cnt <= req_cnt + (block_offset_width_lp+1)'(req_fire);
      resp_cnt <= resp_cnt + (block_offset_width_lp+1)'(|valid_set);
      wr_ptr <= wr_ptr + block_offset_width_lp'(wr_fire);
      valid <= (valid & ~valid_clr) | valid_set;
    end
  always_ff @(posedge clk_i)
    if (in_busy && io.resp_v_i) mem[io.resp_offset_i] <= io.resp_data_i;
  assert property (@(posedge clk_i) disable iff (!reset_n_i) !resp_err)
    else $warning("icache_refill_unit: stray, duplicate or unrequested response");
endmodule

// File: tb/tb_icache_refill_unit.sv
// tb_icache_refill_unit: directed tests of a 4-word and an 8-word refill unit against a behavioural model
module tb_icache_refill_unit;
  logic clk = 0;
  always #5 clk = ~clk;
  logic reset_n;
  logic [1:0] miss_v, req_yumi, resp_v, icache_yumi;
  logic [15:0] miss_pc [2];
  logic [2:0] resp_off [2];
  logic [31:0] resp_data [2];
  wire [1:0] miss_ready, req_v, icache_v, busy, done;
  wire [15:0] req_addr [2];
  wire [15:0] w_pc [2];
  wire [31:0] w_instr [2];
  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int bs = g == 0 ? 4 : 8;
    localparam int ow = g == 0 ? 2 : 3;
    icache_refill_if #(.pc_width_p(16), .block_offset_width_p(ow)) ifc ();
    icache_refill_unit #(
      .icache_tag_width_p(8),
      .icache_entries_p(256),
      .icache_block_size_in_words_p(bs)
    ) dut (
      .clk_i(clk),
      .reset_n_i(reset_n),
      .io(ifc.master)
    );
    assign ifc.miss_v_i = miss_v[g];
    assign ifc.miss_pc_i = miss_pc[g];
    assign ifc.req_yumi_i = req_yumi[g];
    assign ifc.resp_v_i = resp_v[g];
    assign ifc.resp_offset_i = resp_off[g][ow-1:0];
    assign ifc.resp_data_i = resp_data[g];
    assign ifc.icache_yumi_i = icache_yumi[g];
    assign miss_ready[g] = ifc.miss_ready_o;
    assign req_v[g] = ifc.req_v_o;
    assign req_addr[g] = ifc.req_addr_o;
    assign icache_v[g] = ifc.icache_v_o;
    assign w_pc[g] = ifc.icache_w_pc_o;
    assign w_instr[g] = ifc.icache_w_instr_o;
    assign busy[g] = ifc.busy_o;
    assign done[g] = ifc.done_o;
  end
  // model: phase 0 idle, 1 refilling, 2 done pulse
  int ph [2];
  int issued [2];
  int written [2];
  logic [15:0] base [2];
  bit have [2][8];
  logic [31:0] word [2][8];
  int checks = 0, errors = 0, cyc = 0, ndone = 0, nv = 0;
  bit armed = 0;
  logic [15:0] wpc [$];
  logic [15:0] rlog [$];
  logic [31:0] wdat [$];
  int wcyc [$];
  function automatic int bsz(int g);
    return g == 0 ? 4 : 8;
  endfunction
  function automatic logic [31:0] dat(logic [15:0] a);
    return {16'hbeef, a};
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic compare();
    for (int g = 0; g < 2; g++) begin
      bit iv, rv;
      iv = ph[g] == 1 ? have[g][written[g]] : 1'b0;
      rv = ph[g] == 1 && issued[g] < bsz(g);
      chk($sformatf("g%0d miss_ready", g), miss_ready[g], ph[g] == 0);
      chk($sformatf("g%0d busy", g), busy[g], ph[g] != 0);
      chk($sformatf("g%0d done", g), done[g], ph[g] == 2);
      chk($sformatf("g%0d req_v", g), req_v[g], rv);
      chk($sformatf("g%0d icache_v", g), icache_v[g], iv);
      if (rv) chk($sformatf("g%0d req_addr", g), req_addr[g], base[g] + 16'(issued[g]));
      if (iv) begin
        chk($sformatf("g%0d w_pc", g), w_pc[g], base[g] + 16'(written[g]));
        chk($sformatf("g%0d w_instr", g), w_instr[g], word[g][written[g]]);
      end
    end
  endtask
  task automatic model_step();
    for (int g = 0; g < 2; g++) begin
      int bs;
      bit iv;
      bs = bsz(g);
      if (!reset_n || (ph[g] == 0 && miss_v[g])) begin
        if (!reset_n) armed = 1;
        ph[g] = reset_n ? 1 : 0;
        if (reset_n) base[g] = miss_pc[g] & ~16'(bs - 1);
        issued[g] = 0;
        written[g] = 0;
        for (int i = 0; i < 8; i++) have[g][i] = 0;
      end else if (ph[g] == 1) begin
        iv = have[g][written[g]];
        if (issued[g] < bs && req_yumi[g]) issued[g]++;
        if (iv && icache_yumi[g]) begin
          have[g][written[g]] = 0;
          written[g]++;
          if (written[g] == bs) ph[g] = 2;
        end
        if (resp_v[g]) begin
          word[g][resp_off[g] & 3'(bs - 1)] = resp_data[g];
          have[g][resp_off[g] & 3'(bs - 1)] = 1;
        end
      end else ph[g] = 0;
    end
  endtask
  task automatic tick();
    @(negedge clk);
    if (armed) compare();
    for (int g = 0; g < 2; g++) begin
      if (icache_v[g] === 1'b1 && icache_yumi[g]) begin
        wpc.push_back(w_pc[g]);
        wdat.push_back(w_instr[g]);
        wcyc.push_back(cyc);
      end
      if (req_v[g] === 1'b1 && req_yumi[g]) rlog.push_back(req_addr[g]);
      if (done[g] === 1'b1) ndone++;
      if (icache_v[g] === 1'b1) nv++;
    end
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask
  task automatic zero();
    miss_v = 0;
    req_yumi = 0;
    resp_v = 0;
    icache_yumi = 0;
    for (int g = 0; g < 2; g++) begin
      miss_pc[g] = 0;
      resp_off[g] = 0;
      resp_data[g] = 0;
    end
  endtask
  task automatic clear_logs();
    wpc.delete();
    wdat.delete();
    wcyc.delete();
    rlog.delete();
    ndone = 0;
  endtask
  // responder answers each accepted request in order one cycle later
  task automatic refill(int g, logic [15:0] pc, bit stall, int stop_at, int ghost);
    int bs, d0, n;
    bit pv;
    logic [2:0] po;
    bs = bsz(g);
    d0 = ndone;
    pv = 0;
    po = 0;
    miss_v[g] = 1;
    miss_pc[g] = pc;
    tick();
    miss_v[g] = 0;
    for (n = 0; n < 80; n++) begin
      resp_v[g] = pv;
      resp_off[g] = po;
      resp_data[g] = dat((pc & ~16'(bs - 1)) | 16'(po));
      req_yumi[g] = req_v[g] && (!stall || $urandom_range(0, 1) == 1);
      pv = req_yumi[g];
      po = req_addr[g][2:0] & 3'(bs - 1);
      icache_yumi[g] = 1;
      if (n == ghost) begin
        miss_v[g] = 1;
        miss_pc[g] = 16'h5555;
        chk("ghost miss_ready", miss_ready[g], 0);
      end
      tick();
      miss_v[g] = 0;
      if (ndone != d0 || (stop_at >= 0 && wpc.size() >= stop_at)) break;
    end
    if (stop_at >= 0) chk("stop writes", wpc.size(), stop_at);
    else chk("refill done", ndone - d0, 1);
    zero();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    int d0, c0;
    int oo [4] = '{3, 1, 0, 2};
    int ec [4] = '{3, 4, 5, 6};
    reset_n = 0;
    zero();
    tick();
    tick();
    reset_n = 1;
    tick();
    chk("rst miss_ready", miss_ready[0], 1);
    chk("rst busy", busy[0], 0);
    chk("rst req_v", req_v[1], 0);
    // in-order block at 0x1235
    clear_logs();
    refill(0, 16'h1235, 0, -1, -1);
    chk("t1 nwr", wpc.size(), 4);
    chk("t1 nreq", rlog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1 req", rlog[i], 16'h1234 + 16'(i));
      chk("t1 pc", wpc[i], 16'h1234 + 16'(i));
      chk("t1 data", wdat[i], 32'hbeef1234 + 32'(i));
    end
    chk("t1 back-to-back", wcyc[3] - wcyc[0], 3);
    chk("t1 done pulses", ndone, 1);
    // out-of-order responses 3,1,0,2
    clear_logs();
    miss_v[0] = 1;
    miss_pc[0] = 16'h2468;
    tick();
    miss_v[0] = 0;
    for (int i = 0; i < 4; i++) begin
      req_yumi[0] = req_v[0];
      tick();
    end
    req_yumi[0] = 0;
    icache_yumi[0] = 1;
    c0 = cyc;
    for (int i = 0; i < 4; i++) begin
      resp_v[0] = 1;
      resp_off[0] = 3'(oo[i]);
      resp_data[0] = dat(16'h2468 | 16'(oo[i]));
      tick();
    end
    resp_v[0] = 0;
    for (int n = 0; n < 10 && ndone == 0; n++) tick();
    chk("t2 done pulses", ndone, 1);
    chk("t2 nwr", wpc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2 pc", wpc[i], 16'h2468 + 16'(i));
      chk("t2 data", wdat[i], 32'hbeef2468 + 32'(i));
      chk("t2 write cycle", wcyc[i] - c0, ec[i]);
    end
    zero();
    // icache stalls 5 cycles with offset 0 ready
    clear_logs();
    miss_v[0] = 1;
    miss_pc[0] = 16'h2000;
    tick();
    miss_v[0] = 0;
    for (int i = 0; i < 4; i++) begin
      req_yumi[0] = req_v[0];
      tick();
    end
    req_yumi[0] = 0;
    resp_v[0] = 1;
    resp_off[0] = 0;
    resp_data[0] = 32'h600dc0de;
    tick();
    resp_v[0] = 0;
    for (int i = 0; i < 5; i++) begin
      chk("t3 hold v", icache_v[0], 1);
      chk("t3 hold pc", w_pc[0], 16'h2000);
      chk("t3 hold instr", w_instr[0], 32'h600dc0de);
      tick();
    end
    icache_yumi[0] = 1;
    tick();
    chk("t3 first write", wpc.size(), 1);
    chk("t3 first pc", wpc[0], 16'h2000);
    for (int i = 1; i < 4; i++) begin
      resp_v[0] = 1;
      resp_off[0] = 3'(i);
      resp_data[0] = dat(16'h2000 | 16'(i));
      tick();
    end
    resp_v[0] = 0;
    for (int n = 0; n < 10 && ndone == 0; n++) tick();
    chk("t3 nwr", wpc.size(), 4);
    chk("t3 last data", wdat[3], 32'hbeef2003);
    zero();
    // 8-word block with random request stalls
    clear_logs();
    refill(1, 16'h3456, 1, -1, -1);
    chk("t4 nreq", rlog.size(), 8);
    chk("t4 nwr", wpc.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("t4 req", rlog[i], 16'h3450 + 16'(i));
      chk("t4 pc", wpc[i], 16'h3450 + 16'(i));
    end
    chk("t4 req_v after", req_v[1], 0);
    // second miss while busy, then a stray response while idle
    clear_logs();
    refill(0, 16'h1240, 0, -1, 2);
    chk("t5 nwr", wpc.size(), 4);
    chk("t5 pc0", wpc[0], 16'h1240);
    chk("t5 pc3", wpc[3], 16'h1243);
    d0 = nv;
    resp_v[0] = 1;
    resp_off[0] = 1;
    resp_data[0] = 32'hdeadbeef;
    tick();
    resp_v[0] = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("t5 stray writes", nv - d0, 0);
    chk("t5 ready", miss_ready[0], 1);
    // reset after two of four writes
    clear_logs();
    refill(0, 16'h1300, 0, 2, -1);
    reset_n = 0;
    tick();
    reset_n = 1;
    chk("t6 ready", miss_ready[0], 1);
    chk("t6 req_v", req_v[0], 0);
    chk("t6 icache_v", icache_v[0], 0);
    chk("t6 busy", busy[0], 0);
    chk("t6 done", done[0], 0);
    tick();
    clear_logs();
    refill(0, 16'h1300, 0, -1, -1);
    chk("t6 nwr", wpc.size(), 4);
    for (int i = 0; i < 4; i++) chk("t6 pc", wpc[i], 16'h1300 + 16'(i));
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
